// File: rtl/tinker_mem_if.sv
// Fetch and data request/response bundle for tinker_mem_ctrl.
// master drives requests, slave (the controller) drives ready/response.
interface tinker_mem_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ready, if_rvalid, if_rdata, if_err,
    input  d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ready, if_rvalid, if_rdata, if_err,
    output d_ready, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/tinker_mem_ctrl.sv
// Single-outstanding byte-array memory shared by a fetch and a data port.
// Optional macro TINKER_MEM_BOUNDS_CHECK_EN flags out-of-range accesses instead of wrapping.
module tinker_mem_ctrl #(
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  tinker_mem_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        ptr_d;

  logic [7:0]  mem [MEM_BYTES];

  logic        pend_is_d;
  logic        pend_we;
  logic        pend_err;
  logic [63:0] pend_data;

  logic        if_rvalid_q;
  logic        if_err_q;
  logic [31:0] if_rdata_q;
  logic        d_rvalid_q;
  logic        d_err_q;
  logic [63:0] d_rdata_q;

  logic        open_st;
  logic        pick_d;
  logic        acc_d;
  logic        acc_f;
  logic        accept;
  logic        contested;
  logic        d_oob;
  logic        f_oob;
  logic [AW-1:0] d_idx [8];
  logic [AW-1:0] f_idx [4];
  logic [63:0] d_rd;
  logic [31:0] f_rd;

  logic        issue;
  logic        r_is_d;
  logic        r_we;
  logic        r_err;
  logic [63:0] r_data;

  // Ready is offered only to the port that would win arbitration this cycle.
  always_comb begin
    open_st = (state == IDLE) || (state == RESP);
    if (bus.d_req && !bus.if_req)      pick_d = 1'b1;
    else if (bus.if_req && !bus.d_req) pick_d = 1'b0;
    else                               pick_d = ptr_d;
  end

  assign bus.d_ready  = open_st && pick_d;
  assign bus.if_ready = open_st && !pick_d;
  assign acc_d        = bus.d_ready && bus.d_req;
  assign acc_f        = bus.if_ready && bus.if_req;
  assign accept       = acc_d || acc_f;
  assign contested    = bus.d_req && bus.if_req;

  always_comb begin
    d_rd = '0;
    f_rd = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      d_idx[k] = bus.d_addr[AW-1:0] + AW'(k);
      d_rd[8*k +: 8] = mem[d_idx[k]];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      f_idx[k] = bus.if_addr[AW-1:0] + AW'(k);
      f_rd[8*k +: 8] = mem[f_idx[k]];
    end
  end

`ifdef TINKER_MEM_BOUNDS_CHECK_EN
  assign d_oob = ({1'b0, bus.d_addr}  + 65'd8) > 65'(MEM_BYTES);
  assign f_oob = ({1'b0, bus.if_addr} + 65'd4) > 65'(MEM_BYTES);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.d_addr[63:AW], bus.if_addr[63:AW]};
  assign d_oob = 1'b0;
  assign f_oob = 1'b0;
`endif

  // Response payload comes from the pending buffer after WAIT, or straight
  // from the accepting request when LATENCY=1 skips WAIT entirely.
  always_comb begin
    issue = ((state == WAIT) && (wait_cnt == '0)) || (accept && (LATENCY == 1));
    if (state == WAIT) begin
      r_is_d = pend_is_d;
      r_we   = pend_we;
      r_err  = pend_err;
      r_data = pend_data;
    end else begin
      r_is_d = acc_d;
      r_we   = acc_d && bus.d_we;
      r_err  = acc_d ? d_oob : f_oob;
      r_data = acc_d ? (d_oob ? '0 : d_rd) : {32'b0, (f_oob ? 32'b0 : f_rd)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && acc_d && bus.d_we && !d_oob) begin
      for (int unsigned k = 0; k < 8; k++) begin
        mem[d_idx[k]] <= bus.d_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ptr_d       <= 1'b1;
      pend_is_d   <= 1'b0;
      pend_we     <= 1'b0;
      pend_err    <= 1'b0;
      pend_data   <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;

      if (issue) begin
        if (r_is_d) begin
          d_rvalid_q <= 1'b1;
          d_err_q    <= r_err;
          if (!r_we) d_rdata_q <= r_data;
        end else begin
          if_rvalid_q <= 1'b1;
          if_err_q    <= r_err;
          if_rdata_q  <= r_data[31:0];
        end
      end

      case (state)
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        default: begin
          if (accept) begin
            pend_is_d <= r_is_d;
            pend_we   <= r_we;
            pend_err  <= r_err;
            pend_data <= r_data;
            if (contested) ptr_d <= acc_f;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(LATENCY - 2);
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule
